em_buf_free_list: RTL and testbench

- Manages the free pool of edit-memory buffer pointers.
- Sits directly downstream of the edit-memory shared RAM. It consumes the buffer-release strobe (em_rel_buf_valid / em_rel_buf_ptr) that the RAM emits after each buffer is read out.
- Hands free pointers back to the processing-unit write side, which sources pu_data_buf_ptr.
- Implemented as a pointer FIFO in a ram_1r1w, with a self-initialising fill sequencer after reset.

---
 rtl/em_buf_free_list.sv | 115 +++++++++++
 tb/tb_em_buf_free_list.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/em_buf_free_list.sv
// Free pool of edit-memory buffer pointers kept as a pointer FIFO, self-filled with 0..NUM_BUFS-1 after reset.
// Alloc ack/nack and overflow pulse 2 cycles after the strobe; no backpressure, refused requests nack and excess releases drop.
module em_buf_free_list #(
    parameter int BPTR_NBITS = 4,
    parameter int NUM_BUFS   = 1 << BPTR_NBITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  em_rel_buf_valid,
    input  logic [BPTR_NBITS-1:0] em_rel_buf_ptr,
    input  logic                  buf_alloc_req,
    output logic                  buf_alloc_ack,
    output logic [BPTR_NBITS-1:0] buf_alloc_ptr,
    output logic                  buf_alloc_nack,
    output logic                  free_buf_avail,
    output logic [BPTR_NBITS:0]   free_buf_count,
    output logic                  init_done,
    output logic                  fl_overflow_err
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [BPTR_NBITS:0]   FULL_CNT = (BPTR_NBITS+1)'(NUM_BUFS);
    localparam logic [BPTR_NBITS-1:0] LAST_IDX = BPTR_NBITS'(NUM_BUFS - 1);
    localparam logic [BPTR_NBITS-1:0] PTR_ONE  = BPTR_NBITS'(1);

    logic [0:0]            state;
    logic [BPTR_NBITS-1:0] rd_ptr;
    logic [BPTR_NBITS-1:0] wr_ptr;
    logic [BPTR_NBITS:0]   count;
    logic                  rel_q;
    logic [BPTR_NBITS-1:0] rel_ptr_q;
    logic                  acc_q;
    logic                  nck_q;
    logic [BPTR_NBITS-1:0] rd_dat;
    logic [BPTR_NBITS-1:0] mem [NUM_BUFS];

    logic                  running;
    logic                  alloc_accept;
    logic                  rel_commit;
    logic                  rel_drop;
    logic                  mem_wen;
    logic [BPTR_NBITS-1:0] mem_wdat;

    // Releases commit in the same cycle they are checked, so count already
    // holds every earlier commit and is the pending count for the full test.
    always_comb begin
        running      = (state == ST_RUN);
        alloc_accept = buf_alloc_req & running & (count != '0);
        rel_commit   = rel_q & running & (count != FULL_CNT);
        rel_drop     = rel_q & ~rel_commit;
        mem_wen      = ~running | rel_commit;
        mem_wdat     = running ? rel_ptr_q : wr_ptr;
    end

    // Pointer storage: registered read, no reset on the array itself.
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem[wr_ptr] <= mem_wdat;
        end
        rd_dat <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_INIT;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            rel_q           <= 1'b0;
            rel_ptr_q       <= '0;
            acc_q           <= 1'b0;
            nck_q           <= 1'b0;
            buf_alloc_ack   <= 1'b0;
            buf_alloc_ptr   <= '0;
            buf_alloc_nack  <= 1'b0;
            free_buf_avail  <= 1'b0;
            free_buf_count  <= '0;
            init_done       <= 1'b0;
            fl_overflow_err <= 1'b0;
        end else begin
            if (mem_wen) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (alloc_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (!running) begin
                if (wr_ptr == LAST_IDX) begin
                    state <= ST_RUN;
                    count <= FULL_CNT;
                end
            end else begin
                count <= count + {{BPTR_NBITS{1'b0}}, rel_commit}
                               - {{BPTR_NBITS{1'b0}}, alloc_accept};
            end

            rel_q     <= em_rel_buf_valid;
            rel_ptr_q <= em_rel_buf_ptr;
            acc_q     <= alloc_accept;
            nck_q     <= buf_alloc_req & ~alloc_accept;

            buf_alloc_ack   <= acc_q;
            buf_alloc_ptr   <= acc_q ? rd_dat : '0;
            buf_alloc_nack  <= nck_q;
            fl_overflow_err <= rel_drop;
            free_buf_count  <= count;
            free_buf_avail  <= running & (count != '0);
            init_done       <= running;
        end
    end

endmodule

// File: tb/tb_em_buf_free_list.sv
// Directed bench for em_buf_free_list with 16 buffers; expected values worked out by hand.
module tb_em_buf_free_list;

    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          em_rel_buf_valid = 1'b0;
    logic [BW-1:0] em_rel_buf_ptr = '0;
    logic          buf_alloc_req = 1'b0;
    logic          buf_alloc_ack;
    logic [BW-1:0] buf_alloc_ptr;
    logic          buf_alloc_nack;
    logic          free_buf_avail;
    logic [BW:0]   free_buf_count;
    logic          init_done;
    logic          fl_overflow_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    em_buf_free_list #(.BPTR_NBITS(BW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .em_rel_buf_valid (em_rel_buf_valid),
        .em_rel_buf_ptr   (em_rel_buf_ptr),
        .buf_alloc_req    (buf_alloc_req),
        .buf_alloc_ack    (buf_alloc_ack),
        .buf_alloc_ptr    (buf_alloc_ptr),
        .buf_alloc_nack   (buf_alloc_nack),
        .free_buf_avail   (free_buf_avail),
        .free_buf_count   (free_buf_count),
        .init_done        (init_done),
        .fl_overflow_err  (fl_overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_init();
        rst_n = 1'b0;
        em_rel_buf_valid = 1'b0;
        buf_alloc_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (17) step();
    endtask

    // n back-to-back requests; each ack checked two cycles later against exp_q
    task automatic alloc_burst(input int n, input string tag);
        int e;
        for (int c = 0; c <= n; c++) begin
            buf_alloc_req = (c < n);
            step();
            if (c >= 1) begin
                e = exp_q.pop_front();
                check_val({tag, "_ack"}, int'(buf_alloc_ack), 1);
                check_val({tag, "_ptr"}, int'(buf_alloc_ptr), e);
            end
        end
        buf_alloc_req = 1'b0;
    endtask

    initial begin
        // 1: reset values, init duration, request during INIT
        repeat (3) step();
        check_val("rst_ack", int'(buf_alloc_ack), 0);
        check_val("rst_nack", int'(buf_alloc_nack), 0);
        check_val("rst_cnt", int'(free_buf_count), 0);
        check_val("rst_avail", int'(free_buf_avail), 0);
        check_val("rst_init", int'(init_done), 0);
        check_val("rst_ovf", int'(fl_overflow_err), 0);
        rst_n = 1'b1;
        buf_alloc_req = 1'b1;
        step();
        buf_alloc_req = 1'b0;
        step();
        check_val("init_nack", int'(buf_alloc_nack), 1);
        check_val("init_nack_ack", int'(buf_alloc_ack), 0);
        repeat (14) step();
        check_val("init_done_16", int'(init_done), 0);
        step();
        check_val("init_done_17", int'(init_done), 1);
        check_val("init_cnt", int'(free_buf_count), 16);
        check_val("init_avail", int'(free_buf_avail), 1);

        // 2: three back-to-back allocations
        exp_q = '{0, 1, 2};
        alloc_burst(3, "t2");
        check_val("t2_cnt", int'(free_buf_count), 13);

        // 3: drain the pool, then one more request
        reset_init();
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        alloc_burst(16, "t3");
        buf_alloc_req = 1'b1;
        step();
        buf_alloc_req = 1'b0;
        step();
        check_val("t3_nack", int'(buf_alloc_nack), 1);
        check_val("t3_ack", int'(buf_alloc_ack), 0);
        check_val("t3_avail", int'(free_buf_avail), 0);
        check_val("t3_cnt", int'(free_buf_count), 0);

        // 4: release into empty pool; request one cycle later refused, two later granted
        em_rel_buf_valid = 1'b1;
        em_rel_buf_ptr = 4'd9;
        step();
        em_rel_buf_valid = 1'b0;
        buf_alloc_req = 1'b1;
        step();
        step();
        buf_alloc_req = 1'b0;
        check_val("t4_nack", int'(buf_alloc_nack), 1);
        check_val("t4_nack_ack", int'(buf_alloc_ack), 0);
        check_val("t4_cnt1", int'(free_buf_count), 1);
        step();
        check_val("t4_ack", int'(buf_alloc_ack), 1);
        check_val("t4_ptr", int'(buf_alloc_ptr), 9);
        check_val("t4_nack2", int'(buf_alloc_nack), 0);
        check_val("t4_cnt0", int'(free_buf_count), 0);

        // 5: pool at 5, release and allocate aligned so commit and accept coincide
        reset_init();
        for (int i = 0; i < 11; i++) exp_q.push_back(i);
        alloc_burst(11, "t5pre");
        check_val("t5_cnt_start", int'(free_buf_count), 5);
        exp_q = '{11, 12, 13, 14, 15, 10, 9, 8, 7, 6};
        for (int c = 0; c < 12; c++) begin
            int e;
            em_rel_buf_valid = (c < 10);
            em_rel_buf_ptr = BW'(10 - c);
            buf_alloc_req = (c >= 1 && c <= 10);
            step();
            check_val("t5_cnt", int'(free_buf_count), 5);
            if (c >= 2) begin
                e = exp_q.pop_front();
                check_val("t5_ack", int'(buf_alloc_ack), 1);
                check_val("t5_ptr", int'(buf_alloc_ptr), e);
            end
        end
        em_rel_buf_valid = 1'b0;
        buf_alloc_req = 1'b0;
        check_val("t5_ovf", int'(fl_overflow_err), 0);

        // 6: overflow on full pool, reset with ack in flight, reset mid-INIT
        reset_init();
        em_rel_buf_valid = 1'b1;
        em_rel_buf_ptr = 4'd3;
        step();
        em_rel_buf_valid = 1'b0;
        step();
        check_val("t6_ovf", int'(fl_overflow_err), 1);
        step();
        check_val("t6_ovf_once", int'(fl_overflow_err), 0);
        check_val("t6_cnt_full", int'(free_buf_count), 16);
        buf_alloc_req = 1'b1;
        step();
        buf_alloc_req = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_val("t6_no_ack", int'(buf_alloc_ack), 0);
        check_val("t6_no_nack", int'(buf_alloc_nack), 0);
        check_val("t6_rst_cnt", int'(free_buf_count), 0);
        rst_n = 1'b1;
        em_rel_buf_valid = 1'b1;
        em_rel_buf_ptr = 4'd5;
        step();
        em_rel_buf_valid = 1'b0;
        step();
        check_val("t6_init_ovf", int'(fl_overflow_err), 1);
        repeat (6) step();
        rst_n = 1'b0;
        step();
        check_val("t6_mid_init", int'(init_done), 0);
        check_val("t6_mid_ovf", int'(fl_overflow_err), 0);
        rst_n = 1'b1;
        repeat (16) step();
        check_val("t6_refill_16", int'(init_done), 0);
        step();
        check_val("t6_refill_17", int'(init_done), 1);
        check_val("t6_refill_cnt", int'(free_buf_count), 16);
        exp_q = '{0, 1, 2};
        alloc_burst(3, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
